mem_port_arbiter: RTL

//  Shares the single-port unified memory of cpu_pipeline between instruction fetch (IF) and data access (DM).
//  - Accepts one request at a time over valid/ready handshakes and drives one memory transaction per request.
//  - Returns a one-cycle response pulse to the owning requester.
//  - DM has priority over IF; a starvation counter forces an IF grant so fetch always makes progress.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_prio_select.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_XLEN_DEF   = 32;
    localparam int unsigned ARB_ADDR_W_DEF = 32;

    // Encodings match the original ARB_IDLE/ARB_BUSY_IF/ARB_BUSY_DM values.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_prio_select.sv
// DM-over-IF priority grant with a saturating IF starvation counter.
// The caller gates the valids so grants and counting only happen while
// the arbiter is able to accept a request.
module arb_prio_select #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic dm_valid,
    output logic grant_if,
    output logic grant_dm
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force_if;

    // Combinational grant and next starvation count.
    always_comb begin
        force_if     = (starve_cnt_q == CNT_W'(STARVE_MAX));
        grant_dm     = dm_valid & ~force_if;
        grant_if     = if_valid & (~dm_valid | force_if);
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (if_valid && grant_dm && !force_if) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF)
// and data access (DM): one transaction per accepted request, one-cycle
// response pulse to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = ARB_XLEN_DEF,
    parameter int unsigned ADDR_W     = ARB_ADDR_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [XLEN-1:0]     if_rdata,
    input  logic                dm_valid,
    output logic                dm_ready,
    input  logic                dm_we,
    input  logic [XLEN/8-1:0]   dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [XLEN-1:0]     dm_wdata,
    output logic                dm_rsp_valid,
    output logic [XLEN-1:0]     dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [XLEN/8-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic                dm_rsp_valid_q, dm_rsp_valid_d;
    logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]     dm_rdata_q, dm_rdata_d;
    logic                accept_win;
    logic                grant_if, grant_dm;

    // Requests are only offered in IDLE outside the response cycle, so a
    // transaction occupies at least three cycles; readys stay low in reset.
    always_comb begin
        accept_win = rst & (state_q == ARB_IDLE) & ~(if_rsp_valid_q | dm_rsp_valid_q);
    end

    arb_prio_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid & accept_win),
        .dm_valid (dm_valid & accept_win),
        .grant_if (grant_if),
        .grant_dm (grant_dm)
    );

    assign if_ready     = grant_if;
    assign dm_ready     = grant_dm;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_be       = mem_be_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign if_rsp_valid = if_rsp_valid_q;
    assign dm_rsp_valid = dm_rsp_valid_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;

    // FSM next state: latch request on accept, complete on mem_ack.
    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_be_d       = mem_be_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if_rsp_valid_d = 1'b0;
        dm_rsp_valid_d = 1'b0;
        if_rdata_d     = if_rdata_q;
        dm_rdata_d     = dm_rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_dm) begin
                    state_d     = ARB_BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (grant_if) begin
                    state_d     = ARB_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            ARB_BUSY_IF: begin
                if (mem_ack) begin
                    state_d        = ARB_IDLE;
                    mem_req_d      = 1'b0;
                    if_rdata_d     = mem_rdata;
                    if_rsp_valid_d = 1'b1;
                end
            end
            ARB_BUSY_DM: begin
                if (mem_ack) begin
                    state_d        = ARB_IDLE;
                    mem_req_d      = 1'b0;
                    dm_rdata_d     = mem_rdata;
                    dm_rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State, memory-side and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ARB_IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_be_q       <= mem_be_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            dm_rsp_valid_q <= dm_rsp_valid_d;
            if_rdata_q     <= if_rdata_d;
            dm_rdata_q     <= dm_rdata_d;
        end
    end

endmodule
